// File: rtl/ultra_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel ultrasonic ranging controller.
package ultra_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StPost,
    StHoldoff
  } state_e;

  function automatic int unsigned tick_div(input int unsigned clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // One counter serves trigger, timeout and holdoff phases, so size it for the longest.
  function automatic int unsigned us_cnt_width(input int unsigned timeout_us,
                                               input int unsigned holdoff_us);
    int unsigned longest;
    longest = (timeout_us > holdoff_us) ? timeout_us : holdoff_us;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/ultra_array_if.sv
// Result stream of the ranging controller: one measurement per valid/ready transfer.
interface ultra_array_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned W      = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            res_valid;
  logic            res_ready;
  logic [CH_W-1:0] res_ch;
  logic [W-1:0]    res_us;
  logic            res_timeout;

  modport master (
    output res_valid,
    output res_ch,
    output res_us,
    output res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_ch,
    input  res_us,
    input  res_timeout,
    output res_ready
  );

endinterface

// File: rtl/us_tick_gen.sv
// Free-running prescaler producing a single-cycle pulse once per microsecond.
module us_tick_gen
  import ultra_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic tick
);

  localparam int unsigned TICK_DIV = tick_div(CLK_HZ);
  localparam int unsigned DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/ultra_array.sv
// Round-robin HC-SR04 style ranging controller: triggers each channel in turn, times the echo
// in microseconds and posts one result per measurement on a single-entry valid/ready slot.
module ultra_array
  import ultra_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12_000_000,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned W          = 16,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned HOLDOFF_US = 10000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic [W-1:0]      near_thresh_us,
  output logic [NUM_CH-1:0] trig,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] near,
  ultra_array_if.master     res
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = us_cnt_width(TIMEOUT_US, HOLDOFF_US);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_US - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [W-1:0]     W_MAX     = '1;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      width_q, width_d;
  logic              tmo_q, tmo_d;

  logic [NUM_CH-1:0] echo_s1_q, echo_s2_q, echo_d_q;
  logic [NUM_CH-1:0] trig_q, trig_d;
  logic [NUM_CH-1:0] near_q;
  logic              res_valid_q, res_timeout_q;
  logic [CH_W-1:0]   res_ch_q;
  logic [W-1:0]      res_us_q;

  logic tick;
  logic echo_rise, echo_fall;
  logic slot_free, load;

  us_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .tick    (tick)
  );

  // Only the selected channel's edges matter; other echoes are ignored.
  assign echo_rise = echo_s2_q[ch_q] & ~echo_d_q[ch_q];
  assign echo_fall = ~echo_s2_q[ch_q] & echo_d_q[ch_q];

  // A slot being drained this cycle counts as free, so back-to-back results need no bubble.
  assign slot_free = ~res_valid_q | res.res_ready;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      cnt_q     <= '0;
      width_q   <= '0;
      tmo_q     <= 1'b0;
      echo_s1_q <= '0;
      echo_s2_q <= '0;
      echo_d_q  <= '0;
      trig_q    <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      width_q   <= width_d;
      tmo_q     <= tmo_d;
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_d_q  <= echo_s2_q;
      trig_q    <= trig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StTrig;
          cnt_d   = '0;
        end
      end
      StTrig: begin
        if (tick) begin
          if (cnt_q == TRIG_LAST) begin
            state_d = StWaitRise;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWaitRise: begin
        if (echo_rise) begin
          state_d = StMeasure;
          width_d = '0;
        end else if (tick) begin
          if (cnt_q == TMO_LAST) begin
            state_d = StPost;
            tmo_d   = 1'b1;
            width_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StMeasure: begin
        if (echo_fall) begin
          state_d = StPost;
          tmo_d   = 1'b0;
        end else if (tick) begin
          if (width_q != W_MAX) begin
            width_d = width_q + 1'b1;
          end
          // Timeout budget runs from trigger fall, so cnt keeps counting from WAIT_RISE.
          if (cnt_q == TMO_LAST) begin
            state_d = StPost;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StPost: begin
        if (slot_free) begin
          state_d = StHoldoff;
          cnt_d   = '0;
        end
      end
      StHoldoff: begin
        if (tick) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = StIdle;
            ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    trig_d = '0;
    if (state_q == StTrig) begin
      trig_d[ch_q] = 1'b1;
    end
    load = (state_q == StPost) && slot_free;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      res_us_q      <= '0;
      res_timeout_q <= 1'b0;
      near_q        <= '0;
    end else begin
      if (load) begin
        res_valid_q   <= 1'b1;
        res_ch_q      <= ch_q;
        res_us_q      <= width_q;
        res_timeout_q <= tmo_q;
        if (!tmo_q) begin
          near_q[ch_q] <= (width_q < near_thresh_us);
        end
      end else if (res.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign trig            = trig_q;
  assign near            = near_q;
  assign res.res_valid   = res_valid_q;
  assign res.res_ch      = res_ch_q;
  assign res.res_us      = res_us_q;
  assign res.res_timeout = res_timeout_q;

endmodule

// File: doc/ultra_array.md
# ultra_array

Multi-channel ultrasonic ranging controller. It is the parametrised successor to the single-sensor trigger/echo path. It fires NUM_CH HC-SR04-class sensors one at a time in round-robin order, times each echo pulse in microseconds against a programmable timeout, and posts one result per measurement on a valid/ready stream. It sits between the sensor pins at the FPGA top level and the helmet's proximity-alert logic, and also drives a per-channel `near` flag.

## Interface
Parameters:
- CLK_HZ, 12_000_000: sys_clk frequency; TICK_DIV = CLK_HZ/1_000_000 (integer, ≥2)
- NUM_CH, 4: sensor channels, 1..8
- W, 16: echo-width counter/result width in µs
- TRIG_US, 10: trigger pulse length in µs
- TIMEOUT_US, 30000: maximum µs from trigger fall to echo fall
- HOLDOFF_US, 10000: quiet time after each measurement, before the next channel fires

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous, active-high reset
- enable  in  1  scan enable; sampled only in IDLE
- near_thresh_us  in  W  near-flag threshold in µs
- trig  out  NUM_CH  one-hot trigger pins
- echo  in  NUM_CH  raw echo pins (asynchronous)
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_ch  out  $clog2(NUM_CH) (min 1)  channel of the result
- res_us  out  W  echo width in µs
- res_timeout  out  1  measurement timed out
- near  out  NUM_CH  latched flag per channel: last valid width < near_thresh_us

## Operation
- Echo inputs pass through a 2-flop synchronizer per channel. Edge detection uses the synchronized value against its 1-cycle delayed copy.
- Microsecond tick: a single-cycle pulse every TICK_DIV sys_clk cycles. All µs counters advance only on a tick.
- FSM states and transitions:
  - IDLE: if enable=1, go to TRIG with ch = current channel.
  - TRIG: trig[ch]=1 for TRIG_US ticks, then WAIT_RISE. The µs counter is cleared on entry.
  - WAIT_RISE: a rising echo[ch] goes to MEASURE with width=0. If the counter reaches TIMEOUT_US, go to POST with timeout=1 and width=0.
  - MEASURE: width increments per tick, saturating at 2^W−1. A falling echo[ch] goes to POST with timeout=0. If the elapsed total reaches TIMEOUT_US, go to POST with timeout=1 and width held.
  - POST: wait until the result slot is empty, then load it and go to HOLDOFF. This is the backpressure point; no trigger fires while stalled.
  - HOLDOFF: HOLDOFF_US ticks, then advance ch (wraps NUM_CH−1→0), then IDLE.
- Result slot: single entry. res_valid is set on load. On the cycle with res_valid & res_ready, res_valid clears. If POST loads on that same cycle, res_valid stays 1 with the new data; no bubble is required.
- near[ch] updates at slot load, only when timeout=0. A timeout leaves near[ch] unchanged.
- Echo on non-selected channels is ignored.
- Deasserting enable mid-measurement lets the current channel finish through HOLDOFF, then the FSM idles.

## Timing
- Reset values: all outputs 0 (trig, res_valid, res_ch, res_us, res_timeout, near). FSM state IDLE, ch=0, prescaler 0.
- trig is registered and asserts 1 cycle after IDLE→TRIG. Pulse width is TRIG_US·TICK_DIV ±1 cycle.
- Echo-to-detect latency is 3 cycles (2 sync + edge register). Width error is ≤1 µs.
- In POST with the slot empty, res_valid rises 1 cycle after entry.
- Reset asserted mid-operation returns everything to reset values on the next edge and forces trig low immediately on that edge. No partial result is posted.
- Echo already high when WAIT_RISE is entered produces no rising edge, so the channel times out.

## Structure
- Package ultra_pkg holds:
  - the state enum (IDLE, TRIG, WAIT_RISE, MEASURE, POST, HOLDOFF)
  - the TICK_DIV derivation
  - the µs counter width, $clog2(max(TIMEOUT_US, HOLDOFF_US)+1)
- Sub-module us_tick_gen (CLK_HZ): the prescaler, outputting `tick`. It is reset by sys_rst.
- Synchronizer, FSM and result slot stay in ultra_array.

## Test plan
- Use CLK_HZ=4_000_000, NUM_CH=2, HOLDOFF_US=20, TIMEOUT_US=500 for speed.
- Single echo: ch0 echo high for 150 µs, 30 µs after trigger fall → res_ch=0, res_us=150±1, res_timeout=0; with near_thresh_us=200, near[0]=1.
- No echo: ch1 echo held low → after 500 µs, res_ch=1, res_timeout=1, res_us=0; near[1] unchanged.
- Backpressure: res_ready=0 across two measurements → first result held stable, trig stays low (FSM stalls in POST); raising res_ready accepts ch0, then the ch1 result appears with no lost data.
- Round-robin/enable: enable=1 continuously → trig order 0,1,0,1 with ≥20 µs gap; enable dropped during ch1 MEASURE → ch1 result posted, then no further trig.
- Reset mid-trigger: sys_rst during TRIG → trig=0 next cycle, res_valid=0, next scan starts on ch0.
